// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment capture block: segment patterns,
// the pattern-to-nibble decoder and the capture FSM state type.
package seg_pkg;

  // Segment order is {a,b,c,d,e,f,g}, active low.
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  typedef enum logic {
    WAIT_BLANK,
    CAPTURE
  } state_t;

  // Returns {valid, nibble}; unknown patterns give valid = 0 and nibble = 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0;
    case (seg)
      SEG_0: r = {1'b1, 4'h0};
      SEG_1: r = {1'b1, 4'h1};
      SEG_2: r = {1'b1, 4'h2};
      SEG_3: r = {1'b1, 4'h3};
      SEG_4: r = {1'b1, 4'h4};
      SEG_5: r = {1'b1, 4'h5};
      SEG_6: r = {1'b1, 4'h6};
      SEG_7: r = {1'b1, 4'h7};
      SEG_8: r = {1'b1, 4'h8};
      SEG_9: r = {1'b1, 4'h9};
      SEG_A: r = {1'b1, 4'hA};
      SEG_B: r = {1'b1, 4'hB};
      SEG_C: r = {1'b1, 4'hC};
      SEG_D: r = {1'b1, 4'hD};
      SEG_E: r = {1'b1, 4'hE};
      SEG_F: r = {1'b1, 4'hF};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_capture_if.sv
// Bundle of display-pin inputs and decoded-frame outputs for seg_capture.
// The master side drives the pins and observes frames; the slave is the capture block.
interface seg_capture_if;
  logic [7:0]  an_in;
  logic [6:0]  seg_in;
  logic [31:0] digits;
  logic [7:0]  digit_mask;
  logic        frame_valid;
  logic        seg_err;
  logic        an_err;
  logic        timeout;

  modport master (
    output an_in, seg_in,
    input  digits, digit_mask, frame_valid, seg_err, an_err, timeout
  );

  modport slave (
    input  an_in, seg_in,
    output digits, digit_mask, frame_valid, seg_err, an_err, timeout
  );
endinterface

// File: rtl/seg_stable_filter.sv
// Qualifies a multi-bit input as stable: one-cycle sample strobe once the value
// has held unchanged for STABLE_CYCLES consecutive cycles.
module seg_stable_filter #(
  parameter int STABLE_CYCLES = 8,
  parameter int WIDTH         = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  output logic             sample
);

  localparam int             CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_FIRE = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] prev;
  logic [CW-1:0]    stable_cnt;
  logic             same;

  assign same = (data == prev);
  // Strobe on the cycle whose edge takes the count to STABLE_CYCLES; saturation
  // keeps a long-held value from firing again.
  assign sample = same && (stable_cnt == CNT_FIRE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '1;
      stable_cnt <= '0;
    end else begin
      prev <= data;
      if (!same)
        stable_cnt <= '0;
      else if (stable_cnt != CNT_MAX)
        stable_cnt <= stable_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_capture.sv
// Seven-segment scan capture: filters, classifies and decodes scan slots and
// publishes 8-digit frames. Define SEG_CAPTURE_SYNC_EN to add the 2-flop pin synchronizer.
module seg_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic         clk,
  input logic         rst,
  seg_capture_if.slave bus
);

  localparam int            IW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  logic [14:0]   pins;
  logic [14:0]   data;
  logic          sample;
  logic [7:0]    an;
  logic [6:0]    seg;
  logic          is_blank;
  logic          is_digit;
  logic [2:0]    idx;
  logic [4:0]    dec;
  state_t        state;
  logic [IW-1:0] idle_cnt;
  logic [31:0]   shadow;
  logic [7:0]    mask;
  logic [31:0]   digits_q;
  logic [7:0]    digit_mask_q;
  logic          frame_valid_q;
  logic          seg_err_q;
  logic          an_err_q;
  logic          timeout_q;

  assign pins = {bus.an_in, bus.seg_in};

`ifdef SEG_CAPTURE_SYNC_EN
  logic [14:0] sync1;
  logic [14:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
    end
  end

  assign data = sync2;
`else
  assign data = pins;
`endif

  seg_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .WIDTH        (15)
  ) u_filter (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .sample(sample)
  );

  assign an       = data[14:7];
  assign seg      = data[6:0];
  assign is_blank = (an == 8'hFF);
  assign is_digit = $onehot(~an);
  assign dec      = seg_decode(seg);

  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (!an[i]) idx = 3'(i);
  end

  // Pulses default low every cycle; a sample always restarts the idle count,
  // so a timeout can never coincide with a sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WAIT_BLANK;
      idle_cnt      <= '0;
      shadow        <= '0;
      mask          <= '0;
      digits_q      <= '0;
      digit_mask_q  <= '0;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      an_err_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      an_err_q      <= 1'b0;
      timeout_q     <= 1'b0;
      case (state)
        WAIT_BLANK: begin
          idle_cnt <= '0;
          if (sample) begin
            if (is_blank) begin
              state  <= CAPTURE;
              shadow <= '0;
              mask   <= '0;
            end else if (!is_digit) begin
              an_err_q <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (sample) begin
            idle_cnt <= '0;
            if (is_blank) begin
              if (mask != '0) begin
                digits_q      <= shadow;
                digit_mask_q  <= mask;
                frame_valid_q <= 1'b1;
              end
              shadow <= '0;
              mask   <= '0;
            end else if (is_digit) begin
              shadow[{idx, 2'b00} +: 4] <= dec[3:0];
              mask[idx]                 <= dec[4];
              seg_err_q                 <= ~dec[4];
            end else begin
              an_err_q <= 1'b1;
              shadow   <= '0;
              mask     <= '0;
              state    <= WAIT_BLANK;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            timeout_q <= 1'b1;
            idle_cnt  <= '0;
            shadow    <= '0;
            mask      <= '0;
            state     <= WAIT_BLANK;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        default: state <= WAIT_BLANK;
      endcase
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_mask  = digit_mask_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.an_err      = an_err_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_seg_capture.sv
// Scenario bench for seg_capture: drives scan slots on the pins and checks
// committed frames against an expected-frame queue plus pulse counts.
module tb_seg_capture;

  localparam int STABLE  = 8;
  localparam int TIMEOUT = 4096;
  localparam int SLOT    = 200;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  m;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_capture_if bus ();

  seg_capture #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int consumed = 0;
  logic [31:0] last_d = '0;
  logic [7:0]  last_m = '0;
  frame_t exp_q[$];

  // Monitor: cycle count plus a record of every pulse the DUT emits.
  int cyc = 0;
  int frame_cnt = 0;
  int seg_err_cnt = 0;
  int an_err_cnt = 0;
  int timeout_cnt = 0;
  int last_timeout_cyc = 0;
  logic [31:0] obs_d [64];
  logic [7:0]  obs_m [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.frame_valid) begin
      if (frame_cnt < 64) begin
        obs_d[frame_cnt] <= bus.digits;
        obs_m[frame_cnt] <= bus.digit_mask;
      end
      frame_cnt <= frame_cnt + 1;
    end
    if (bus.seg_err) seg_err_cnt <= seg_err_cnt + 1;
    if (bus.an_err) an_err_cnt <= an_err_cnt + 1;
    if (bus.timeout) begin
      timeout_cnt      <= timeout_cnt + 1;
      last_timeout_cyc <= cyc;
    end
  end

  function automatic logic [6:0] hex_pat(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic drive_slot(input logic [7:0] an, input logic [6:0] seg, input int cycles);
    @(negedge clk);
    bus.an_in  = an;
    bus.seg_in = seg;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic drive_digit(input int i, input logic [3:0] n, input int cycles);
    logic [7:0] an;
    an    = 8'hFF;
    an[i] = 1'b0;
    drive_slot(an, hex_pat(n), cycles);
  endtask

  task automatic drive_blank();
    drive_slot(8'hFF, 7'h7F, SLOT);
  endtask

  task automatic drive_frame(input logic [31:0] val, input logic [7:0] shown);
    for (int i = 0; i < 8; i++)
      if (shown[i]) drive_digit(i, val[4*i +: 4], SLOT);
  endtask

  // Pops the next expected frame and compares it with the next observed commit.
  task automatic check_frame(input string name);
    frame_t e;
    int waited;
    waited = 0;
    while (frame_cnt <= consumed && waited < 4 * SLOT) begin
      @(negedge clk);
      #1;
      waited++;
    end
    e = exp_q.pop_front();
    last_d = e.d;
    last_m = e.m;
    if (frame_cnt <= consumed) begin
      checks++;
      $display("[TB] FAIL %s frame_wait: no frame_valid within %0d cycles, expected digits %h", name, waited, e.d);
    end else begin
      checks++;
      if (obs_d[consumed] !== e.d)
        $display("[TB] FAIL %s digits: got %h expected %h", name, obs_d[consumed], e.d);
      else passes++;
      checks++;
      if (obs_m[consumed] !== e.m)
        $display("[TB] FAIL %s digit_mask: got %h expected %h", name, obs_m[consumed], e.m);
      else passes++;
      consumed++;
    end
  endtask

  task automatic test_reset();
    bus.an_in  = 8'hFF;
    bus.seg_in = 7'h7F;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (bus.digits !== 32'h0) $display("[TB] FAIL reset digits: got %h expected 0", bus.digits); else passes++;
    checks++; if (bus.digit_mask !== 8'h0) $display("[TB] FAIL reset digit_mask: got %h expected 0", bus.digit_mask); else passes++;
    checks++; if (bus.frame_valid !== 1'b0) $display("[TB] FAIL reset frame_valid: got %b expected 0", bus.frame_valid); else passes++;
    checks++; if (bus.seg_err !== 1'b0) $display("[TB] FAIL reset seg_err: got %b expected 0", bus.seg_err); else passes++;
    checks++; if (bus.an_err !== 1'b0) $display("[TB] FAIL reset an_err: got %b expected 0", bus.an_err); else passes++;
    checks++; if (bus.timeout !== 1'b0) $display("[TB] FAIL reset timeout: got %b expected 0", bus.timeout); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    int f0;
    f0 = frame_cnt;
    drive_blank();
    drive_frame(32'h00051234, 8'hFF);
    checks++;
    if (frame_cnt !== f0) $display("[TB] FAIL first_blank_pulse: got %0d frames expected %0d", frame_cnt, f0);
    else passes++;
    exp_q.push_back('{32'h00051234, 8'hFF});
    drive_blank();
    check_frame("full_frame");
  endtask

  task automatic test_glitch();
    int s0;
    s0 = seg_err_cnt;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        drive_digit(5, 4'hA, SLOT / 2);
        drive_slot(8'hDF, 7'b1111111, 3);
        drive_digit(5, 4'hA, SLOT / 2);
      end else begin
        drive_digit(i, 4'hF - 4'(i), SLOT);
      end
    end
    exp_q.push_back('{32'h89ABCDEF, 8'hFF});
    drive_blank();
    check_frame("glitch");
    checks++;
    if (seg_err_cnt !== s0) $display("[TB] FAIL glitch_seg_err: got %0d pulses expected %0d", seg_err_cnt, s0);
    else passes++;
  endtask

  task automatic test_invalid_pattern();
    int s0;
    s0 = seg_err_cnt;
    drive_digit(0, 4'h7, SLOT);
    drive_digit(1, 4'h6, SLOT);
    drive_slot(8'hFB, 7'b1111111, SLOT);
    drive_frame(32'h01234000, 8'hF8);
    exp_q.push_back('{32'h01234067, 8'hFB});
    drive_blank();
    check_frame("invalid_pattern");
    checks++;
    if (seg_err_cnt !== s0 + 1) $display("[TB] FAIL invalid_seg_err: got %0d pulses expected %0d", seg_err_cnt, s0 + 1);
    else passes++;
  endtask

  task automatic test_an_err();
    int a0;
    int f0;
    a0 = an_err_cnt;
    f0 = frame_cnt;
    drive_digit(0, 4'h3, SLOT);
    drive_slot(8'hFC, hex_pat(4'h1), 1000);
    drive_blank();
    checks++;
    if (an_err_cnt !== a0 + 1) $display("[TB] FAIL an_err_pulse: got %0d pulses expected %0d", an_err_cnt, a0 + 1);
    else passes++;
    checks++;
    if (frame_cnt !== f0) $display("[TB] FAIL an_err_no_commit: got %0d frames expected %0d", frame_cnt, f0);
    else passes++;
    checks++;
    if (bus.digits !== last_d) $display("[TB] FAIL an_err_hold: got %h expected %h", bus.digits, last_d);
    else passes++;
    drive_frame(32'hFEDCBA98, 8'hFF);
    exp_q.push_back('{32'hFEDCBA98, 8'hFF});
    drive_blank();
    check_frame("an_err_recover");
  endtask

  task automatic test_timeout();
    int t0;
    int f0;
    int dt;
    t0 = timeout_cnt;
    f0 = frame_cnt;
    drive_frame(32'h00000555, 8'h07);
    @(negedge clk);
    bus.an_in  = 8'hF7;
    bus.seg_in = hex_pat(4'h9);
    dt = cyc;
    repeat (5000) @(negedge clk);
    #1;
    dt = last_timeout_cyc - dt;
    checks++;
    if (timeout_cnt !== t0 + 1) $display("[TB] FAIL timeout_pulse: got %0d pulses expected %0d", timeout_cnt, t0 + 1);
    else passes++;
    checks++;
    if (dt < TIMEOUT + STABLE + 1 || dt > TIMEOUT + STABLE + 3)
      $display("[TB] FAIL timeout_delay: got %0d cycles expected %0d..%0d", dt, TIMEOUT + STABLE + 1, TIMEOUT + STABLE + 3);
    else passes++;
    checks++;
    if (bus.digits !== last_d) $display("[TB] FAIL timeout_hold: got %h expected %h", bus.digits, last_d);
    else passes++;
    checks++;
    if (frame_cnt !== f0) $display("[TB] FAIL timeout_no_commit: got %0d frames expected %0d", frame_cnt, f0);
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    drive_blank();
    drive_frame(32'h00043210, 8'h1F);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.digits !== 32'h0) $display("[TB] FAIL midreset_digits: got %h expected 0", bus.digits);
    else passes++;
    checks++;
    if (bus.digit_mask !== 8'h0) $display("[TB] FAIL midreset_mask: got %h expected 0", bus.digit_mask);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    f0 = frame_cnt;
    drive_frame(32'h77700000, 8'hE0);
    drive_blank();
    checks++;
    if (frame_cnt !== f0) $display("[TB] FAIL midreset_partial: got %0d frames expected %0d", frame_cnt, f0);
    else passes++;
    drive_frame(32'hC0FFEE12, 8'hFF);
    exp_q.push_back('{32'hC0FFEE12, 8'hFF});
    drive_blank();
    check_frame("after_reset");
  endtask

  task automatic test_back_to_back();
    drive_frame(32'h13579BDF, 8'hFF);
    exp_q.push_back('{32'h13579BDF, 8'hFF});
    drive_blank();
    check_frame("b2b_first");
    drive_digit(0, 4'h9, SLOT);
    drive_frame(32'h2468ACE0, 8'hFE);
    drive_digit(0, 4'h0, SLOT);
    exp_q.push_back('{32'h2468ACE0, 8'hFF});
    drive_blank();
    check_frame("b2b_overwrite");
    drive_frame(32'h00000321, 8'h07);
    exp_q.push_back('{32'h00000321, 8'h07});
    drive_blank();
    check_frame("b2b_partial");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_glitch();
    test_invalid_pattern();
    test_an_err();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (frame_cnt !== consumed) $display("[TB] FAIL frame_count: got %0d frames expected %0d", frame_cnt, consumed);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
# seg_capture

Seven-segment display capture and decode block: samples the multiplexed anode (`an_in`) and cathode (`seg_in`) lines produced by the 8-digit display scanner and reconstructs the hex nibbles shown on each digit. It qualifies each scan slot for stability, decodes segment patterns back to 4-bit values, and publishes a complete 32-bit frame after each blank slot. It sits on the loopback or board-pin side of the display path, for self-check and bench observation of displayed results.

## Interface
- `STABLE_CYCLES`, default 8: consecutive unchanged cycles of `{an_in, seg_in}` before a slot is sampled; minimum 2.
- `TIMEOUT_CYCLES`, default 4096: maximum number of cycles between samples while capturing before the frame is abandoned.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `an_in`  in  8  anode enables, active low; bit i selects digit i.
- `seg_in`  in  7  segments `{a,b,c,d,e,f,g}`, active low.
- `digits`  out  32  last committed frame; digit i is `digits[4i+3:4i]`.
- `digit_mask`  out  8  bit i is 1 if digit i decoded validly in the last committed frame.
- `frame_valid`  out  1  one-cycle pulse when `digits`/`digit_mask` update.
- `seg_err`  out  1  one-cycle pulse on an undecodable segment pattern.
- `an_err`  out  1  one-cycle pulse when more than one anode is low.
- `timeout`  out  1  one-cycle pulse when a capture is abandoned.

## Operation
- Inputs pass through a 2-flop synchronizer. The synchronizer flops reset to all ones (blank).
- Stability filter:
  - `stable_cnt` clears when the synchronized `{an,seg}` differs from its previous value; otherwise it increments, saturating at `STABLE_CYCLES`.
  - A `sample` strobe fires for exactly one cycle, on the cycle the count reaches `STABLE_CYCLES`.
  - A glitch shorter than `STABLE_CYCLES` never produces a sample.
- Slot classification on `sample`:
  - `an == 8'hFF` is a blank slot.
  - Exactly one zero in `an` is a digit slot with index i.
  - Anything else is an anode error.
- Decode table (pattern → nibble):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 1001100→4, 0100100→5, 0100000→6, 0001111→7
  - 0000000→8, 0000100→9, 0001000→A, 1100000→B
  - 0110001→C, 1000010→D, 0110000→E, 0111000→F
  - All other patterns are invalid.
- FSM states are `WAIT_BLANK` and `CAPTURE`. Reset state is `WAIT_BLANK`.
- `WAIT_BLANK`:
  - Blank sample → `CAPTURE`; clear shadow nibbles and shadow mask.
  - Digit samples are ignored.
  - Anode error → pulse `an_err`; stay in `WAIT_BLANK`.
- `CAPTURE`:
  - Valid digit i → `shadow[i]` = nibble, `mask[i]` = 1. A repeated index overwrites.
  - Invalid pattern on digit i → pulse `seg_err`; `shadow[i]` = 0, `mask[i]` = 0.
  - Blank sample with mask ≠ 0 → commit: `digits` = shadow (nibbles with mask 0 are 0), `digit_mask` = mask, pulse `frame_valid`. Then clear the shadow and stay in `CAPTURE`; this blank opens the next frame.
  - Blank sample with mask = 0 → no commit, no pulse.
  - Anode error → pulse `an_err`, discard shadow, → `WAIT_BLANK`.
  - The idle counter counts cycles since the last sample. On reaching `TIMEOUT_CYCLES`: pulse `timeout`, discard shadow, → `WAIT_BLANK`.
- Simultaneous events: the `sample` strobe clears the idle counter in the same cycle, so a timeout and a sample cannot both take effect.

## Timing
- Reset values:
  - `digits` = 0, `digit_mask` = 0.
  - All pulse outputs = 0.
  - FSM = `WAIT_BLANK`.
  - `stable_cnt`, idle counter, shadow and mask = 0.
- `rst` mid-frame discards all partial state immediately; no commit occurs.
- Latency with the synchronizer: `frame_valid` and the updated `digits` appear 2 + `STABLE_CYCLES` + 1 rising edges after a blank pattern first appears on the pins, provided the pins then hold steady.
- `seg_err` and `an_err` are registered at the same position as `frame_valid`: one edge after the `sample` strobe.
- `digits` and `digit_mask` hold between commits.
- At the scanner's rate (1000 clocks per slot), one frame commits every 9000 clocks.

## Configuration
- `SEG_CAPTURE_SYNC_EN` defined: the 2-flop input synchronizer is present; use this for pin-level inputs.
- `SEG_CAPTURE_SYNC_EN` undefined: inputs feed the stability filter directly, for same-clock loopback. All latencies shrink by 2 cycles; behaviour is otherwise identical.

## Structure
- Package `seg_pkg` holds:
  - the 16 segment-pattern constants;
  - a `seg_decode` function returning `{valid, nibble}`;
  - the FSM state enum.
- Sub-module `seg_stable_filter` holds the change detector, saturating counter and `sample` strobe. It is parameterised by `STABLE_CYCLES` and by data width (15).

## Test plan
- Full frame: blank, then digits 0..7 showing 4,3,2,1,5,0,0,0, each held 1000 cycles, then blank → one `frame_valid`, `digits` = 0x00051234, `digit_mask` = 0xFF. The first blank after reset gives no pulse.
- Glitch: `seg_in` flips for 3 cycles mid-slot → no extra sample, no `seg_err`, frame unchanged.
- Invalid pattern 1111111 on digit 2 → one `seg_err` pulse; at the next blank, `digit_mask` = 0xFB and `digits[11:8]` = 0.
- `an_in` = 11111100 held 1000 cycles → one `an_err` pulse. No `frame_valid` at the next blank; the following full frame commits normally.
- Scan stops after digit 3 and holds 5000 cycles → `timeout` pulses 4096 cycles after that sample; `digits` keeps its previous value.
- `rst` asserted for 1 cycle mid-frame → all outputs 0 immediately. The next complete frame commits correctly and the partial frame is never published.
